// File: rtl/hit_centroid_x.sv
`default_nettype none
// ============================================================================
// Module   : hit_centroid_x
// Brief    : Per-frame horizontal centroid of colour-mask hit pixels.
//            Accumulates hit x-sum and hit count over a raster frame, then
//            runs a restoring divide (one quotient bit per clock) at end of
//            frame and presents an 8-bit position held between frames.
// Revision : 1.0  initial release
// ============================================================================
module hit_centroid_x #(
  parameter int X_W       = 10,
  parameter int CNT_W     = 19,
  parameter int SUM_W     = 29,
  parameter int MIN_COUNT = 64,
  parameter int OUT_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_pix_valid,
  input  logic       i_pix_sop,
  input  logic       i_pix_eol,
  input  logic       i_pix_eof,
  input  logic       i_pix_hit,
  output logic [7:0] o_pos,
  output logic       o_pos_valid,
  output logic       o_pos_found,
  output logic       o_busy,
  output logic       o_frame_drop
);

  localparam int IT_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Column tracking and frame accumulators
  logic [X_W-1:0]   r_next_x;
  logic [X_W-1:0]   w_x;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_sum_tot;
  logic [CNT_W-1:0] w_cnt_tot;
  logic             w_eof;
  logic             w_qualify;

  // Divider datapath
  logic [SUM_W-1:0] r_quo;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_div;
  logic [IT_W-1:0]  r_iter;
  logic [CNT_W:0]   w_rem_sh;
  logic             w_qbit;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [SUM_W-1:0] w_quo_sh;
  logic [7:0]       w_pos_sat;

  // FSM strobes
  logic w_load;
  logic w_short;
  logic w_drop;
  logic w_done;

  // Output registers
  logic [7:0] r_pos;
  logic       r_pos_valid;
  logic       r_pos_found;
  logic       r_frame_drop;
  logic       r_short;

  // Current pixel column and running totals including this pixel
  always_comb begin
    w_eof     = i_pix_valid & i_pix_eof;
    w_x       = i_pix_sop ? '0 : r_next_x;
    w_sum_tot = (i_pix_sop ? '0 : r_sum)
              + (i_pix_hit ? {{CNT_W{1'b0}}, w_x} : '0);
    w_cnt_tot = (i_pix_sop ? '0 : r_cnt) + {{(CNT_W-1){1'b0}}, i_pix_hit};
    w_qualify = (w_cnt_tot >= CNT_W'(MIN_COUNT));
  end

  // Column counter: restarts at sop and on the pixel after an eol
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_x <= '0;
    end else if (i_pix_valid) begin
      r_next_x <= i_pix_eol ? '0 : (w_x + X_W'(1));
    end
  end

  // Accumulators: eof hands totals to the divider and clears for the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_pix_valid) begin
      if (i_pix_eof) begin
        r_sum <= '0;
        r_cnt <= '0;
      end else begin
        r_sum <= w_sum_tot;
        r_cnt <= w_cnt_tot;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_short     = 1'b0;
    w_drop      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_eof) begin
          if (w_qualify) begin
            w_load      = 1'b1;
            w_state_nxt = S_DIV;
          end else begin
            w_short = 1'b1;
          end
        end
      end
      S_DIV: begin
        w_drop = w_eof;
        if (r_iter == IT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_drop      = w_eof;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One restoring step: shift in next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so the CNT_W-bit difference
  // is exact.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[SUM_W-1]};
    w_qbit    = (w_rem_sh >= {1'b0, r_div});
    w_rem_nxt = w_qbit ? (w_rem_sh[CNT_W-1:0] - r_div) : w_rem_sh[CNT_W-1:0];
    w_quo_sh  = r_quo >> OUT_SHIFT;
    w_pos_sat = (|w_quo_sh[SUM_W-1:8]) ? 8'hFF : w_quo_sh[7:0];
  end

  // Divider registers: load at qualifying eof, step while in DIV
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_iter <= '0;
    end else if (w_load) begin
      r_quo  <= w_sum_tot;
      r_div  <= w_cnt_tot;
      r_rem  <= '0;
      r_iter <= IT_W'(SUM_W);
    end else if (r_state == S_DIV) begin
      r_quo  <= {r_quo[SUM_W-2:0], w_qbit};
      r_rem  <= w_rem_nxt;
      r_iter <= r_iter - IT_W'(1);
    end
  end

  // Result registers: short frames report not-found one clock after eof
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos        <= '0;
      r_pos_valid  <= 1'b0;
      r_pos_found  <= 1'b0;
      r_frame_drop <= 1'b0;
      r_short      <= 1'b0;
    end else begin
      r_short      <= w_short;
      r_pos_valid  <= w_done | r_short;
      r_frame_drop <= w_drop;
      if (w_done) begin
        r_pos       <= w_pos_sat;
        r_pos_found <= 1'b1;
      end else if (r_short) begin
        r_pos_found <= 1'b0;
      end
    end
  end

  assign o_pos        = r_pos;
  assign o_pos_valid  = r_pos_valid;
  assign o_pos_found  = r_pos_found;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_drop = r_frame_drop;

endmodule
`default_nettype wire

// File: tb/tb_hit_centroid_x.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_centroid_x
// Brief    : Scoreboard bench for hit_centroid_x (default and OUT_SHIFT=0).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hit_centroid_x;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic i_pix_valid = 1'b0, i_pix_sop = 1'b0, i_pix_eol = 1'b0;
  logic i_pix_eof = 1'b0, i_pix_hit = 1'b0;

  logic [7:0] o_pos, o2_pos;
  logic o_pos_valid, o_pos_found, o_busy, o_frame_drop;
  logic o2_pos_valid, o2_pos_found, o2_busy, o2_frame_drop;

  hit_centroid_x u_dut (
    .clk(clk), .reset(reset),
    .i_pix_valid(i_pix_valid), .i_pix_sop(i_pix_sop), .i_pix_eol(i_pix_eol),
    .i_pix_eof(i_pix_eof), .i_pix_hit(i_pix_hit),
    .o_pos(o_pos), .o_pos_valid(o_pos_valid), .o_pos_found(o_pos_found),
    .o_busy(o_busy), .o_frame_drop(o_frame_drop)
  );

  hit_centroid_x #(.OUT_SHIFT(0)) u_dut_s0 (
    .clk(clk), .reset(reset),
    .i_pix_valid(i_pix_valid), .i_pix_sop(i_pix_sop), .i_pix_eol(i_pix_eol),
    .i_pix_eof(i_pix_eof), .i_pix_hit(i_pix_hit),
    .o_pos(o2_pos), .o_pos_valid(o2_pos_valid), .o_pos_found(o2_pos_found),
    .o_busy(o2_busy), .o_frame_drop(o2_frame_drop)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    bit         found;
    logic [7:0] pos;
    logic [7:0] pos0;
  } exp_t;

  exp_t sb[$];
  int   drop_q[$];
  int   b_start = -1000;
  int   busy_until = -1;
  int   drops_seen = 0;

  // reference model state
  int     m_nx = 0;
  longint m_sum = 0;
  longint m_cnt = 0;
  int     last_pos = 0;
  int     last_pos0 = 0;
  logic [7:0] prev_pos = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat8(input longint v);
    return (v > 255) ? 255 : int'(v);
  endfunction

  // Frame-level reference: centroid = floor(sum of hit x / hit count)
  function automatic void model(input bit sop, input bit eol, input bit eof, input bit hit);
    int     x;
    longint q;
    exp_t   e;
    x    = sop ? 0 : m_nx;
    m_nx = eol ? 0 : ((x + 1) % 1024);
    if (sop) begin
      m_sum = 0;
      m_cnt = 0;
    end
    if (hit) begin
      m_sum += x;
      m_cnt++;
    end
    if (eof) begin
      if (cyc <= busy_until) begin
        drop_q.push_back(cyc);
      end else if (m_cnt >= 64) begin
        q         = m_sum / m_cnt;
        last_pos  = sat8(q >> 2);
        last_pos0 = sat8(q);
        e.due = cyc + 30; e.found = 1'b1;
        e.pos = 8'(last_pos); e.pos0 = 8'(last_pos0);
        sb.push_back(e);
        busy_until = cyc + 30;
        b_start    = cyc;
      end else begin
        e.due = cyc + 1; e.found = 1'b0;
        e.pos = 8'(last_pos); e.pos0 = 8'(last_pos0);
        sb.push_back(e);
      end
      m_sum = 0;
      m_cnt = 0;
    end
  endfunction

  task automatic pix(input bit v, input bit sop, input bit eol, input bit eof, input bit hit);
    i_pix_valid = v;
    if (v) begin
      i_pix_sop = sop; i_pix_eol = eol; i_pix_eof = eof; i_pix_hit = hit;
    end else begin
      {i_pix_sop, i_pix_eol, i_pix_eof, i_pix_hit} = 4'($urandom);
    end
    @(posedge clk); #1;
    if (v) model(sop, eol, eof, hit);
    i_pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int w, input int rows, input int xl, input int xh,
                       input int rl, input int rh);
    for (int r = 0; r < rows; r++)
      for (int x = 0; x < w; x++)
        pix(1'b1, (r == 0 && x == 0), (x == w - 1), (r == rows - 1 && x == w - 1),
            (x >= xl && x <= xh && r >= rl && r <= rh));
  endtask

  task automatic rst_seq(input string tag);
    reset = 1'b1;
    i_pix_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_pos"}, o_pos, 0);
    chk({tag, "_pos_valid"}, o_pos_valid, 0);
    chk({tag, "_pos_found"}, o_pos_found, 0);
    chk({tag, "_frame_drop"}, o_frame_drop, 0);
    chk({tag, "_pos_s0"}, o2_pos, 0);
    @(posedge clk); #1;
    sb.delete(); drop_q.delete();
    b_start = -1000; busy_until = -1;
    m_nx = 0; m_sum = 0; m_cnt = 0; last_pos = 0; last_pos0 = 0;
    reset = 1'b0;
  endtask

  // Monitor: pops scoreboard on pos_valid, tracks drops, busy and pos hold
  always @(negedge clk) begin
    bit   exp_drop;
    bit   exp_busy;
    exp_t e;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("pos_valid_missing", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (o_pos_valid) begin
        if (sb.size() == 0) begin
          chk("pos_valid_unexpected", o_pos_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("pos_valid_latency", 32'(cyc), 32'(e.due));
          chk("pos", o_pos, e.pos);
          chk("pos_found", o_pos_found, e.found);
          chk("pos_valid_s0", o2_pos_valid, 1);
          chk("pos_s0", o2_pos, e.pos0);
          chk("pos_found_s0", o2_pos_found, e.found);
        end
      end else begin
        chk("pos_held", o_pos, prev_pos);
      end
      while (drop_q.size() > 0 && drop_q[0] < cyc) begin
        chk("frame_drop_missing", 32'(cyc), 32'(drop_q[0]));
        void'(drop_q.pop_front());
      end
      exp_drop = (drop_q.size() > 0 && drop_q[0] == cyc);
      chk("frame_drop", o_frame_drop, exp_drop);
      chk("frame_drop_s0", o2_frame_drop, exp_drop);
      if (exp_drop) void'(drop_q.pop_front());
      if (o_frame_drop) drops_seen++;
      exp_busy = (cyc >= b_start && cyc <= b_start + 29);
      chk("busy", o_busy, exp_busy);
      chk("busy_s0", o2_busy, exp_busy);
    end
    prev_pos = o_pos;
  end

  initial begin
    int d0;
    int w;
    int rows;
    int p;

    // 1: reset state, idle with junk inputs keeps busy low
    rst_seq("t1_reset");
    repeat (8) begin
      idle(1);
      chk("t1_busy_idle", o_busy, 0);
    end

    // 2: 80 hits at x=100..103 on rows 10..29 -> floor(101.5)>>2 = 25
    frame(110, 30, 100, 103, 10, 29);
    idle(35);
    chk("t2_pos", o_pos, 25);
    chk("t2_pos_found", o_pos_found, 1);

    // 3: 10 hits -> not found, pos held, no divide
    frame(20, 1, 0, 9, 0, 0);
    repeat (3) begin
      chk("t3_busy", o_busy, 0);
      idle(1);
    end
    chk("t3_pos", o_pos, 25);
    chk("t3_pos_found", o_pos_found, 0);

    // 4: 100 hits at x=639 -> 159; unshifted instance saturates at 255
    frame(640, 100, 639, 639, 0, 99);
    idle(35);
    chk("t4_pos", o_pos, 159);
    chk("t4_pos_s0", o2_pos, 255);

    // 5: 64-hit frame (q=31 -> 7) then a frame whose eof lands in DIV
    d0 = drops_seen;
    frame(64, 1, 0, 63, 0, 0);
    frame(10, 1, 0, 9, 0, 0);
    idle(40);
    chk("t5_drop_count", 32'(drops_seen - d0), 1);
    chk("t5_pos", o_pos, 7);

    // 6: reset 5 clocks into DIV aborts the divide
    frame(64, 1, 0, 63, 0, 0);
    idle(4);
    rst_seq("t6_reset");
    idle(40);
    chk("t6_pos_after_abort", o_pos, 0);

    // 6b: sop mid-frame restarts the accumulators (70 hits 0..69 -> 34 -> 8)
    for (int x = 0; x < 20; x++) pix(1'b1, (x == 0), 1'b0, 1'b0, 1'b1);
    frame(70, 1, 0, 69, 0, 0);
    idle(35);
    chk("t6_mid_sop_pos", o_pos, 8);

    // Randomized frames with gaps; some eofs land while busy
    for (int f = 0; f < 15; f++) begin
      w    = $urandom_range(8, 40);
      rows = $urandom_range(1, 4);
      p    = $urandom_range(0, 100);
      for (int r = 0; r < rows; r++)
        for (int x = 0; x < w; x++) begin
          if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
          pix(1'b1, (r == 0 && x == 0), (x == w - 1), (r == rows - 1 && x == w - 1),
              ($urandom_range(0, 99) < p));
        end
      idle($urandom_range(0, 35));
    end

    // Drain outstanding expectations within a bounded window
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && drop_q.size() == 0) break;
      idle(1);
    end
    if (sb.size() != 0 || drop_q.size() != 0)
      chk("drain_timeout", 32'(sb.size() + drop_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
